// File: rtl/dem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dem_sequencer
// Description : Run/pause/direction controller for the 8-bit up/down display
//               counter. It debounces the run button and direction switch,
//               issues a one-cycle count enable at the step rate, and stops
//               or reverses the counter at the programmable limits.
// Revision    : 1.0 - initial release
// ============================================================================
module dem_sequencer #(
   parameter int         STEP_DIV  = 50_000_000,
   parameter int         DB_CYCLES = 1_000_000,
   parameter logic [7:0] UPPER     = 8'hFF,
   parameter logic [7:0] LOWER     = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_btn_run,
   input  logic       i_sw_ud,
   input  logic       i_sw_mode,
   input  logic [7:0] i_cnt_q,
   output logic       o_cnt_en,
   output logic       o_cnt_up,
   output logic       o_cnt_clr,
   output logic [1:0] o_state,
   output logic       o_at_limit
);

   localparam int                c_PSC_W    = $clog2(STEP_DIV);
   localparam int                c_DB_W     = $clog2(DB_CYCLES + 1);
   localparam logic [c_PSC_W-1:0] c_PSC_LAST = c_PSC_W'(STEP_DIV - 1);
   localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_HOLD  = 2'b11
   } state_t;

   logic [1:0]         r_rst_sync;
   logic               w_rst_n;
   logic [1:0]         r_btn_sync;
   logic [1:0]         r_ud_sync;
   logic [1:0]         r_mode_sync;
   logic [1:0]         w_raw_sync;
   logic [1:0]         w_db_lvl;
   logic [1:0]         r_db_prev;
   logic               w_press;
   logic               w_ud_chg;
   logic               r_dir;
   logic               w_at_limit;
   logic               w_tick;
   logic [c_PSC_W-1:0] r_psc;
   logic [c_PSC_W-1:0] w_psc_nxt;
   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_cnt_en;
   logic               r_cnt_clr;
   logic               w_en_nxt;
   logic               w_clr_nxt;
   logic               w_flip;

   // Internal reset: asserts with rst_n, releases two clocks after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   // Two-flop synchronizers for all raw board inputs
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_btn_sync  <= 2'b00;
         r_ud_sync   <= 2'b00;
         r_mode_sync <= 2'b00;
      end else begin
         r_btn_sync  <= {r_btn_sync[0],  i_btn_run};
         r_ud_sync   <= {r_ud_sync[0],   i_sw_ud};
         r_mode_sync <= {r_mode_sync[0], i_sw_mode};
      end
   end

   // Bit 0 = run button, bit 1 = direction switch
   assign w_raw_sync = {r_ud_sync[1], r_btn_sync[1]};

   for (genvar gi = 0; gi < 2; gi++) begin : g_db
      logic [c_DB_W-1:0] r_cnt;
      logic              r_lvl;
      // Accept a new level only after DB_CYCLES consecutive differing samples
      always_ff @(posedge clk or negedge w_rst_n) begin
         if (!w_rst_n) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
         end else if (w_raw_sync[gi] == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == c_DB_LAST) begin
            r_cnt <= '0;
            r_lvl <= w_raw_sync[gi];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
      assign w_db_lvl[gi] = r_lvl;
   end

   // Previous debounced levels for edge detection
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_db_prev <= 2'b00;
      else          r_db_prev <= w_db_lvl;
   end

   assign w_press  = w_db_lvl[0] & ~r_db_prev[0];
   assign w_ud_chg = w_db_lvl[1] ^ r_db_prev[1];

   // Direction follows switch changes; a bounce at a limit inverts it
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)      r_dir <= 1'b1;
      else if (w_ud_chg) r_dir <= w_db_lvl[1];
      else if (w_flip)   r_dir <= ~r_dir;
   end

   assign w_at_limit = r_dir ? (i_cnt_q == UPPER) : (i_cnt_q == LOWER);
   assign w_tick     = (r_state == S_RUN) && (r_psc == c_PSC_LAST);

   // Next state, prescaler and strobes; a press in RUN freezes the prescaler
   always_comb begin
      w_state_nxt = r_state;
      w_psc_nxt   = r_psc;
      w_en_nxt    = 1'b0;
      w_clr_nxt   = 1'b0;
      w_flip      = 1'b0;
      case (r_state)
         S_IDLE, S_HOLD: begin
            w_psc_nxt = '0;
            if (w_press) begin
               w_state_nxt = S_RUN;
               w_clr_nxt   = 1'b1;
            end
         end
         S_RUN: begin
            if (w_press) begin
               w_state_nxt = S_PAUSE;
            end else begin
               w_psc_nxt = w_tick ? '0 : r_psc + 1'b1;
               if (w_tick) begin
                  if (!w_at_limit) begin
                     w_en_nxt = 1'b1;
                  end else if (r_mode_sync[1]) begin
                     w_en_nxt = 1'b1;
                     w_flip   = 1'b1;
                  end else begin
                     w_state_nxt = S_HOLD;
                  end
               end
            end
         end
         S_PAUSE: begin
            if (w_press) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, prescaler and registered output strobes
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= S_IDLE;
         r_psc     <= '0;
         r_cnt_en  <= 1'b0;
         r_cnt_clr <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_psc     <= w_psc_nxt;
         r_cnt_en  <= w_en_nxt;
         r_cnt_clr <= w_clr_nxt;
      end
   end

   assign o_cnt_en   = r_cnt_en;
   assign o_cnt_clr  = r_cnt_clr;
   assign o_cnt_up   = r_dir;
   assign o_state    = r_state;
   assign o_at_limit = w_at_limit;

endmodule
`default_nettype wire

// File: doc/dem_sequencer.md
# dem_sequencer

Run/pause/direction controller for the 8-bit up/down display counter. It debounces the run button and the direction switch, then generates the one-cycle count enable at the step rate and the direction and clear strobes. It also watches the counter value so it can stop or reverse at programmable limits. It sits between the raw board inputs and the counter, replacing the free-running step clock with a clock-enable on the single system clock.

## Interface

Parameters:
- STEP_DIV, 50_000_000: clk cycles per count step (1 Hz at 50 MHz); must be ≥2.
- DB_CYCLES, 1_000_000: consecutive stable synchronized samples required to accept a new input level.
- UPPER, 8'hFF: upper count limit.
- LOWER, 8'h00: lower count limit; LOWER < UPPER.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- btn_run  in  1  raw run/pause push button, active-high, asynchronous, bouncing.
- sw_ud  in  1  raw direction switch: 1 = up, 0 = down.
- sw_mode  in  1  limit mode, synchronized only (no debounce): 0 = stop at limit, 1 = bounce (reverse).
- cnt_q  in  8  current counter value, fed back from the counter.
- cnt_en  out  1  one-cycle count-step enable.
- cnt_up  out  1  direction to apply: 1 = increment, 0 = decrement.
- cnt_clr  out  1  one-cycle synchronous clear request (counter loads LOWER).
- state  out  2  IDLE=00, RUN=01, PAUSE=10, HOLD=11.
- at_limit  out  1  high while cnt_q equals the limit in the current direction.

## Operation

- Input conditioning:
  - btn_run and sw_ud each pass through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive equal samples differing from the current level.
  - press = one-cycle pulse on the debounced btn_run rising edge.
- Direction register dir:
  - Loaded from debounced sw_ud on every debounced sw_ud change.
  - Inverted by a bounce at a limit.
  - cnt_up = dir at all times.
- Prescaler:
  - Counts 0..STEP_DIV-1 only in RUN; tick when it equals STEP_DIV-1, then it wraps to 0.
  - Frozen (value held) in PAUSE.
  - Cleared to 0 in IDLE and HOLD, and on every transition into RUN from IDLE or HOLD.
- State machine:
  - IDLE: press → RUN; cnt_clr pulses in the transition cycle.
  - RUN, press → PAUSE. No cnt_en that cycle, even if tick coincides (press wins).
  - RUN, tick, not at limit → cnt_en.
  - RUN, tick, at limit, sw_mode=0 → HOLD, no cnt_en.
  - RUN, tick, at limit, sw_mode=1 → dir inverted and cnt_en issued in the same cycle with the new direction. The counter moves away from the limit.
  - PAUSE: press → RUN; prescaler resumes from its held value.
  - HOLD: press → RUN; cnt_clr pulses; dir is unchanged.
- at_limit = (dir & cnt_q==UPPER) | (!dir & cnt_q==LOWER); combinational from registered dir and cnt_q.
- A direction switch change in any state updates dir only; it does not alter state.

## Timing

- Reset values:
  - state=IDLE, cnt_en=0, cnt_clr=0, prescaler=0.
  - dir=1, so cnt_up=1.
  - Debounced levels=0, synchronizers=0.
- Reset is asserted asynchronously and released synchronously (2-FF reset synchronizer).
- Reset mid-RUN drops cnt_en immediately; no clear is issued.
- Input latency:
  - press appears 2 (sync) + DB_CYCLES + 1 cycles after a clean btn_run rise.
  - Glitches shorter than DB_CYCLES produce nothing.
- Step timing:
  - Entering RUN in cycle t (prescaler 0) gives the first cnt_en in cycle t+STEP_DIV.
  - After that, one cnt_en every STEP_DIV cycles.
- cnt_en, cnt_clr and state are registered outputs. cnt_en and cnt_clr are exactly one cycle wide and are never asserted together.
- The counter updates on the edge that samples cnt_en. The limit check uses cnt_q as of the tick cycle, so the counter never passes UPPER or LOWER.

## Test plan

Bench parameters: STEP_DIV=4, DB_CYCLES=3, LOWER=8'h02, UPPER=8'h05, behavioural counter on the bench.

1. Reset held low mid-operation, then released → state=00, cnt_en=0, cnt_clr=0, cnt_up=1 throughout reset. btn_run bounce pulses of 1–2 cycles → no state change.
2. Clean btn_run press, sw_ud=1, sw_mode=0 → cnt_clr once, state=01, counter 02,03,04,05 with cnt_en every 4 cycles. Next tick gives state=11, no cnt_en, counter stays 05, at_limit=1.
3. Same run with sw_mode=1 → sequence 02..05,04,03,02,03, and cnt_up toggles in the reversing cnt_en cycles.
4. Press in RUN two cycles after a step → state=10, no cnt_en. Press again → first cnt_en exactly 2 cycles after re-entering RUN (prescaler resumed).
5. Press timed so its pulse lands in the tick cycle → state=10, no cnt_en, counter unchanged.
6. In HOLD at 05, flip sw_ud to 0 and press → cnt_clr, counter 02, dir=0. Next tick at LOWER with sw_mode=0 → HOLD again, no cnt_en.
